// File: rtl/output_reader.sv
// Drains the CNN output memory and streams its words over a valid/ready interface.
// Holds busy while a drain is in progress so the writer leaves the buffer alone.
module output_reader #(
    parameter  int WIDTH   = 16,
    parameter  int SIZE    = 64,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [LOGSIZE:0]   count,
    output logic               busy,
    output logic               done,
    output logic [LOGSIZE-1:0] mem_rd_addr,
    output logic               mem_rd_en,
    input  logic [WIDTH-1:0]   mem_data,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam logic [LOGSIZE:0] MAX_LEN = (LOGSIZE+1)'(SIZE);

    state_t             r_state;
    logic [LOGSIZE:0]   r_rd_ptr;
    logic [LOGSIZE:0]   r_len;
    logic [LOGSIZE:0]   r_sent;
    logic               r_busy;
    logic               r_done;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;

    logic               w_rd_en;
    logic               w_xfer;
    logic [LOGSIZE:0]   w_ptr_next;
    logic [LOGSIZE:0]   w_sent_next;
    logic [LOGSIZE:0]   w_len_sat;

    // A read may refill the output register only when it is empty or being drained this cycle.
    assign w_rd_en     = (r_state == READ) && (!r_out_valid || out_ready);
    assign w_xfer      = r_out_valid && out_ready;
    assign w_ptr_next  = r_rd_ptr + 1'b1;
    assign w_sent_next = r_sent + 1'b1;
    assign w_len_sat   = (count > MAX_LEN) ? MAX_LEN : count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rd_ptr    <= '0;
            r_len       <= '0;
            r_sent      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_xfer) begin
                r_sent <= w_sent_next;
            end

            if (w_rd_en) begin
                r_out_data  <= mem_data;
                r_out_valid <= 1'b1;
                r_rd_ptr    <= w_ptr_next;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_len    <= w_len_sat;
                            r_rd_ptr <= '0;
                            r_sent   <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= READ;
                        end
                    end
                end
                READ: begin
                    if (w_rd_en && (w_ptr_next == r_len)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_xfer && (w_sent_next == r_len)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign mem_rd_en   = w_rd_en;
    assign mem_rd_addr = (r_state == READ) ? r_rd_ptr[LOGSIZE-1:0] : '0;

endmodule

// File: doc/output_reader.md
# output_reader

Drains the CNN output memory after a layer completes and streams its contents out over a valid/ready interface. Sits between `output_memory`'s read port and the downstream consumer (host interface or next stage). It drives the memory's `rd_addr`/`rd_en` and consumes its combinational read data. It holds `busy` so the writer side knows not to overwrite the buffer mid-drain.

## Interface
Parameters:
- WIDTH, 16, data word width; matches output memory.
- SIZE, 64, output memory depth in words.
- LOGSIZE (localparam), $clog2(SIZE), memory address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to drain `count` words starting at address 0.
- count  in  LOGSIZE+1  number of words to drain (0..SIZE); sampled with accepted `start`.
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle pulse marking the end of a drain.
- mem_rd_addr  out  LOGSIZE  read address to output memory.
- mem_rd_en  out  1  read strobe to output memory.
- mem_data  in  WIDTH  output memory read data, combinational from `mem_rd_addr`.
- out_data  out  WIDTH  streamed word.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  consumer accepts the word when high with `out_valid`.

## Operation
- The FSM has three states: IDLE, READ and DRAIN.
- Internal registers:
  - `rd_ptr` (LOGSIZE+1 bits): next address to read.
  - `len` (LOGSIZE+1 bits): latched word count.
  - `sent` (LOGSIZE+1 bits): number of completed handshakes.
- IDLE:
  - `start` with count>0: latch `len`=min(count,SIZE), clear `rd_ptr` and `sent`, then go to READ.
  - `start` with count==0: pulse `done` the next cycle and stay in IDLE. `busy` does not assert and there is no `out_valid`.
- READ:
  - `mem_rd_addr` = `rd_ptr[LOGSIZE-1:0]`.
  - `mem_rd_en` = (!out_valid || out_ready).
  - When `mem_rd_en` is high: `out_data` <= `mem_data`, `out_valid` <= 1, `rd_ptr` += 1.
  - When `rd_ptr`+1 == `len` on a read: go to DRAIN.
- DRAIN:
  - `mem_rd_en` = 0.
  - Hold the last word until it completes its handshake.
- Handshake:
  - A transfer occurs on any edge with out_valid && out_ready; `sent` += 1.
  - If no new read loads the output register, `out_valid` <= 0.
- Completion:
  - When the transfer with `sent`+1 == `len` completes: pulse `done` in the next cycle, clear `busy` and return to IDLE.
- `start` is ignored while `busy` is high. `start` is legal in the `done` cycle, because the FSM is already in IDLE.
- While `out_valid` is high and `out_ready` is low, `out_data` stays stable.
- `mem_rd_addr` never exceeds SIZE-1, and the pointer never wraps within a drain.
- Reset (asynchronous, including mid-drain) forces:
  - the FSM to IDLE;
  - `rd_ptr`, `len` and `sent` to 0;
  - all outputs to 0: `busy`, `done`, `out_valid`, `out_data`, `mem_rd_en`, `mem_rd_addr`.
- A drain interrupted by reset does not resume.

## Timing
- `start` is accepted at edge E0; the FSM is in READ in cycle 1, with `mem_rd_addr`=0 and `mem_rd_en`=1.
- The first `out_valid` appears in cycle 2, so latency from `start` to the first word is 2 cycles.
- With `out_ready` held high, throughput is one word per cycle with no bubbles: word i is valid in cycle 2+i.
- `done` is high in the cycle after the final handshake. For count=N with no backpressure, `done` is in cycle N+2.
- `busy` is high from cycle 1 through the cycle before `done`. `done` and !`busy` coincide.
- Backpressure stalls the read pointer in the same cycle: no words are lost or duplicated, and there is at most one word in flight.

## Test plan
- Reset, then idle: all outputs are 0.
  - Assert reset_n=0 mid-drain: `out_valid`, `busy` and `mem_rd_en` drop immediately (asynchronously).
- Preload mem[0..3]=16'h0011,0022,0033,0044; start with count=4 and out_ready=1:
  - `out_data` shows 0011,0022,0033,0044 in cycles 2..5;
  - `done` pulses in cycle 6;
  - `busy` is high in cycles 1..5.
- Same drain with out_ready=0 in cycles 3..5:
  - 0022 is held stable with `out_valid`=1 and `mem_rd_en`=0 during the stall;
  - the full sequence is delivered exactly once, and `done` moves out by 3 cycles.
- start with count=0: `done` pulses in cycle 1, and `busy`/`out_valid` are never asserted.
- start with count=SIZE (64), then count=70: both drain exactly 64 words in addresses 0..63, with no address wrap.
- Pulse start again in cycle 3 of a drain with count=2 and count=5: the second start is ignored, and exactly 2 words are followed by `done`.
